// File: rtl/alu_operand_stager_pkg.sv
// Shared definitions for the ALU operand stager and any later stage that
// reuses its state encoding or byte count.
package alu_operand_stager_pkg;

  localparam int OP_WIDTH     = 32;
  localparam int BYTES_PER_OP = OP_WIDTH / 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } stager_state_e;

  function automatic int bytes_per_op(input int width);
    return width / 8;
  endfunction

  // The byte index needs at least one bit, even for an 8-bit operand.
  function automatic int idx_width(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction

endpackage

// File: rtl/alu_operand_stager_if.sv
// Byte input handshake, operand-pair output handshake and pair counter
// shared by the stager and its neighbours.
interface alu_operand_stager_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] pair_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, a, b, out_valid, pair_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, a, b, out_valid, pair_cnt
  );

endinterface

// File: rtl/alu_operand_stager.sv
// Packs an LSB-first byte stream into operands A and B, then holds the pair
// stable for the ALU until it is taken.
module alu_operand_stager
  import alu_operand_stager_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 clr,
  alu_operand_stager_if.slave bus
);

  localparam int BPO   = bytes_per_op(WIDTH);
  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPO - 1);

  stager_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;

    // clr drops any partial or pending pair but keeps the operand registers.
    if (clr) begin
      state_d = LOAD_A;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (bus.in_valid) begin
            a_d[{idx_q, 3'b000} +: 8] = bus.in_data;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = LOAD_B;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            b_d[{idx_q, 3'b000} +: 8] = bus.in_data;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = HOLD;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            cnt_d   = cnt_q + CNT_W'(1);
            idx_d   = '0;
            state_d = LOAD_A;
          end
        end
        default: begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q != HOLD) && !rst;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.pair_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_operand_stager.sv
// Bench for alu_operand_stager: a byte-queue reference model checked every
// cycle, a vector table for the basic pair, and directed corner sequences.
module tb_alu_operand_stager;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  alu_operand_stager_if #(.WIDTH(32), .CNT_W(16)) bus ();
  alu_operand_stager_if #(.WIDTH(32), .CNT_W(2))  bus_w ();

  // The narrow-counter instance sees the same stimulus as the main one.
  assign bus_w.in_valid  = bus.in_valid;
  assign bus_w.in_data   = bus.in_data;
  assign bus_w.out_ready = bus.out_ready;

  alu_operand_stager #(.WIDTH(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  alu_operand_stager #(.WIDTH(32), .CNT_W(2)) dut_w (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus_w)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: bytes collected toward the current pair plus the
  // operand images and the completed-pair count.
  logic [7:0]  got[$];
  int          m_cnt;
  logic [31:0] m_a, m_b;

  task automatic tick();
    int k;
    if (rst) begin
      got.delete();
      m_cnt = 0;
      m_a   = '0;
      m_b   = '0;
    end else if (clr) begin
      got.delete();
    end else if (got.size() == 8) begin
      if (bus.out_ready) begin
        m_cnt++;
        got.delete();
      end
    end else if (bus.in_valid) begin
      k = got.size();
      if (k < 4) m_a[8*k +: 8] = bus.in_data;
      else       m_b[8*(k-4) +: 8] = bus.in_data;
      got.push_back(bus.in_data);
    end
    @(posedge clk);
    #1;
    check("in_ready",   64'(bus.in_ready),  64'((got.size() < 8) && !rst));
    check("out_valid",  64'(bus.out_valid), 64'(got.size() == 8));
    check("pair_cnt",   64'(bus.pair_cnt),  64'(m_cnt % 65536));
    check("pair_cnt_w", 64'(bus_w.pair_cnt), 64'(m_cnt % 4));
    check("a", 64'(bus.a), 64'(m_a));
    check("b", 64'(bus.b), 64'(m_b));
  endtask

  task automatic send(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_cnt;
    logic        chk_ab;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic [15:0] e_cnt,
                              input logic chk_ab, input logic [31:0] e_a, input logic [31:0] e_b);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_cnt = e_cnt; v.chk_ab = chk_ab; v.e_a = e_a; v.e_b = e_b;
    return v;
  endfunction

  vec_t tbl[$];
  logic [7:0] gap_bytes[8];
  logic [7:0] basic_bytes[8];
  int wrap_seq[5];

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.out_ready = 1'b0;

    // Reset held for two cycles with a byte on offer.
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_a",        64'(bus.a), 64'h0);
    check("rst_b",        64'(bus.b), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_in_ready", 64'(bus.in_ready), 64'h0);
    check("rst_pair_cnt", 64'(bus.pair_cnt), 64'h0);
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'h1);

    // Basic pair, back-to-back bytes, out_ready held high.
    basic_bytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b1, basic_bytes[i], 1'b1, (i != 7), (i == 7), 16'd0,
                       (i == 3 || i == 7), (i == 3 || i == 7) ? 32'h11223344 : 32'h0,
                       (i == 7) ? 32'hAABBCCDD : 32'h0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd1, 1'b1, 32'h11223344, 32'hAABBCCDD));
    foreach (tbl[i]) begin
      bus.in_valid  = tbl[i].iv;
      bus.in_data   = tbl[i].d;
      bus.out_ready = tbl[i].ordy;
      tick();
      check($sformatf("vec%0d_in_ready", i),  64'(bus.in_ready),  64'(tbl[i].e_ir));
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
      check($sformatf("vec%0d_pair_cnt", i),  64'(bus.pair_cnt),  64'(tbl[i].e_cnt));
      if (tbl[i].chk_ab) begin
        check($sformatf("vec%0d_a", i), 64'(bus.a), 64'(tbl[i].e_a));
        if (tbl[i].e_ov) check($sformatf("vec%0d_b", i), 64'(bus.b), 64'(tbl[i].e_b));
      end
    end
    bus.in_valid = 1'b0;

    // Backpressure: pair held while a new byte waits.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 64'(bus.out_valid), 64'h1);
      check("bp_in_ready",  64'(bus.in_ready),  64'h0);
      check("bp_a", 64'(bus.a), 64'h13121110);
      check("bp_b", 64'(bus.b), 64'h17161514);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_cnt_after_hs", 64'(bus.pair_cnt), 64'd2);
    check("bp_a_kept", 64'(bus.a), 64'h13121110);
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("bp_55_taken", 64'(bus.a[7:0]), 64'h55);
    check("bp_cnt_once", 64'(bus.pair_cnt), 64'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Gapped input stream.
    bus.out_ready = 1'b1;
    gap_bytes = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        bus.in_data = 8'($urandom);
        tick();
      end
      send(gap_bytes[i]);
    end
    check("gap_ov", 64'(bus.out_valid), 64'h1);
    check("gap_a",  64'(bus.a), 64'hFFFF0000);
    check("gap_b",  64'(bus.b), 64'h0000FFFF);
    check("gap_and", 64'(bus.a & bus.b), 64'h0);
    tick();
    check("gap_cnt", 64'(bus.pair_cnt), 64'd3);

    // clr in the middle of B, then a fresh pair.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'(8'hE0 + i));
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_in_ready", 64'(bus.in_ready), 64'h1);
    check("clr_cnt", 64'(bus.pair_cnt), 64'd3);
    for (int i = 0; i < 8; i++) send(8'(i + 1));
    check("clr_ov", 64'(bus.out_valid), 64'h1);
    check("clr_a", 64'(bus.a), 64'h04030201);
    check("clr_b", 64'(bus.b), 64'h08070605);
    // clr coinciding with the output handshake must not count the pair.
    clr = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_hs_ov",  64'(bus.out_valid), 64'h0);
    check("clr_hs_cnt", 64'(bus.pair_cnt), 64'd3);

    // Counter wrap on the 2-bit instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wrap_seq = '{1, 2, 3, 0, 1};
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 8; i++) send(8'($urandom));
      tick();
      check($sformatf("wrap%0d", p), 64'(bus_w.pair_cnt), 64'(wrap_seq[p]));
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      clr           = ($urandom_range(0, 39) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
